// File: rtl/cpu6_lsu_if.sv
// rtl/cpu6_lsu_if.sv - request/response and memory bus bundle for cpu6_lsu
//
// Purpose: groups the core-side request/response handshake and the
// memory-side bus of the load/store unit into one interface.
// Modports:
//   slave  - the LSU view: takes requests, returns responses, drives the bus.
//   master - the environment view: the core plus the data memory/bus.
// Signals:
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//   rsp_valid/rsp_rdata/rsp_err/rsp_errcode
//   mem_valid/mem_ready/mem_we/mem_addr/mem_wstrb/mem_wdata
//   mem_rvalid/mem_rdata
interface cpu6_lsu_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic [1:0]        rsp_errcode;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_errcode,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_errcode,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cpu6_lsu.sv
// rtl/cpu6_lsu.sv - cpu6 load/store unit, one outstanding bus transaction
//
// Purpose: accepts a load/store request from the execute stage, checks size
// and alignment, issues one bus request with lane strobes and replicated
// store data, waits for read data on loads, and returns a one-cycle response
// with extended load data or an error code (01 misaligned, 10 timeout,
// 11 illegal size).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - cpu6_lsu_if.slave: request, response and memory bus signals
// Parameters:
//   XLEN    - 32 or 64
//   TIMEOUT - cycles allowed from acceptance to completion, 0 = never
module cpu6_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       reset,
  cpu6_lsu_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  // The counter only has to reach TIMEOUT-1: the timeout fires in the cycle
  // that would make the elapsed count equal TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            r_we;
  logic            r_uns;
  logic [1:0]      r_size;
  logic [OW-1:0]   r_off;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [NB-1:0]   mem_wstrb_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;
  logic [1:0]      rsp_code_q;

  logic [OW-1:0]   in_off;
  logic            size_bad;
  logic            misaligned;
  logic [NB-1:0]   strb_base;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] lmask;
  logic [XLEN-1:0] ldata;
  logic            sbit;
  logic            tmo;

  assign in_off   = bus.req_addr[OW-1:0];
  assign size_bad = (XLEN == 32) && (bus.req_size == 2'b11);
  assign tmo      = (TIMEOUT > 0) && (cnt == TLAST);

  // Request decode: alignment, strobe pattern and lane-replicated data.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = '1;
    wrep       = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        strb_base = NB'(1);
        wrep      = {NB{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = in_off[0];
        strb_base  = NB'(3);
        wrep       = {(NB/2){bus.req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |in_off[1:0];
        strb_base  = NB'(15);
        wrep       = {(NB/4){bus.req_wdata[31:0]}};
      end
      default: misaligned = |in_off;
    endcase
  end

  // Load return path: shift the addressed lane down, then extend by size.
  always_comb begin
    sh = bus.mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00:   begin lmask = XLEN'(8'hFF);         sbit = sh[7];      end
      2'b01:   begin lmask = XLEN'(16'hFFFF);      sbit = sh[15];     end
      2'b10:   begin lmask = XLEN'(32'hFFFF_FFFF); sbit = sh[31];     end
      default: begin lmask = '1;                   sbit = sh[XLEN-1]; end
    endcase
    ldata = sh & lmask;
    if (!r_uns && sbit) ldata = ldata | ~lmask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= 2'b00;
    end else begin
      // Saturating, so a load whose bus grant landed on the last allowed
      // cycle still times out on its first idle WAIT_R cycle.
      if ((state == S_REQ || state == S_WAIT_R) && cnt != TLAST)
        cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we   <= bus.req_we;
            r_uns  <= bus.req_unsigned;
            r_size <= bus.req_size;
            r_off  <= in_off;
            cnt    <= '0;
            if (size_bad || misaligned) begin
              state       <= S_RESP;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              rsp_code_q  <= size_bad ? 2'b11 : 2'b01;
            end else begin
              state       <= S_REQ;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[XLEN-1:OW], {OW{1'b0}}};
              mem_wstrb_q <= bus.req_we ? (strb_base << in_off) : '0;
              mem_wdata_q <= wrep;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ready) begin
            if (r_we) begin
              state       <= S_RESP;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b0;
              rsp_code_q  <= 2'b00;
            end else begin
              state <= S_WAIT_R;
            end
          end else if (tmo) begin
            state       <= S_RESP;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_code_q  <= 2'b10;
          end
        end
        S_WAIT_R: begin
          if (bus.mem_rvalid) begin
            state       <= S_RESP;
            rsp_rdata_q <= ldata;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= 2'b00;
          end else if (tmo) begin
            state       <= S_RESP;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_code_q  <= 2'b10;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.mem_valid   = (state == S_REQ);
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_errcode = rsp_code_q;
endmodule

// File: tb/tb_cpu6_lsu.sv
// tb/tb_cpu6_lsu.sv - self-checking bench for cpu6_lsu (XLEN 32 and 64)
`timescale 1ns/1ps
module tb_cpu6_lsu;
  localparam int T32 = 4;
  localparam int T64 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel64;
  logic        req_valid, req_we, req_unsigned, mem_ready, mem_rvalid;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;

  cpu6_lsu_if #(.XLEN(32)) b32 ();
  cpu6_lsu_if #(.XLEN(64)) b64 ();

  assign b32.req_valid    = req_valid & ~sel64;
  assign b32.req_we       = req_we;
  assign b32.req_size     = req_size;
  assign b32.req_unsigned = req_unsigned;
  assign b32.req_addr     = req_addr[31:0];
  assign b32.req_wdata    = req_wdata[31:0];
  assign b32.mem_ready    = mem_ready;
  assign b32.mem_rvalid   = mem_rvalid;
  assign b32.mem_rdata    = mem_rdata[31:0];

  assign b64.req_valid    = req_valid & sel64;
  assign b64.req_we       = req_we;
  assign b64.req_size     = req_size;
  assign b64.req_unsigned = req_unsigned;
  assign b64.req_addr     = req_addr;
  assign b64.req_wdata    = req_wdata;
  assign b64.mem_ready    = mem_ready;
  assign b64.mem_rvalid   = mem_rvalid;
  assign b64.mem_rdata    = mem_rdata;

  cpu6_lsu #(.XLEN(32), .TIMEOUT(T32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  cpu6_lsu #(.XLEN(64), .TIMEOUT(T64)) u64 (.clk(clk), .reset(reset), .bus(b64));

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_we;
  logic [1:0]  o_rsp_errcode;
  logic [63:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;

  always_comb begin
    if (sel64) begin
      o_req_ready = b64.req_ready;  o_rsp_valid = b64.rsp_valid;
      o_rsp_err = b64.rsp_err;      o_rsp_errcode = b64.rsp_errcode;
      o_rsp_rdata = b64.rsp_rdata;  o_mem_valid = b64.mem_valid;
      o_mem_we = b64.mem_we;        o_mem_addr = b64.mem_addr;
      o_mem_wdata = b64.mem_wdata;  o_mem_wstrb = b64.mem_wstrb;
    end else begin
      o_req_ready = b32.req_ready;  o_rsp_valid = b32.rsp_valid;
      o_rsp_err = b32.rsp_err;      o_rsp_errcode = b32.rsp_errcode;
      o_rsp_rdata = {32'd0, b32.rsp_rdata};
      o_mem_valid = b32.mem_valid;  o_mem_we = b32.mem_we;
      o_mem_addr = {32'd0, b32.mem_addr};
      o_mem_wdata = {32'd0, b32.mem_wdata};
      o_mem_wstrb = {4'd0, b32.mem_wstrb};
    end
  end

  int total = 0;
  int bad = 0;
  logic [63:0] hold_rd   [2];
  logic [1:0]  hold_code [2];
  logic [63:0] l_addr, l_wstrb, l_wdata, l_rdata;
  logic [1:0]  l_code;
  int          l_rc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference load extension: pick the addressed bytes, extend to XLEN.
  function automatic logic [63:0] ld_ext(input int xl, input logic [1:0] sz, input logic uns,
                                         input logic [63:0] a, input logic [63:0] rd);
    int nb, off;
    logic [63:0] v, m;
    nb  = 1 << sz;
    off = int'(a % (xl / 8));
    v   = (xl == 32) ? (rd & 64'hFFFF_FFFF) : rd;
    v   = v >> (8 * off);
    m   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v   = v & m;
    if (!uns && v[8 * nb - 1]) v = v | ~m;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One complete transaction: mem_ready in cycle 1+rdly, mem_rvalid
  // rvdly cycles after the cycle following the grant.
  task automatic txn(input logic s64, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input int rdly, input int vdly, input string tag);
    int xl, tl, lanes, nb, off, r, v, m, rc;
    logic        pre_err, mv;
    logic [1:0]  code;
    logic [63:0] a, w, ea, es, ew, er;
    xl    = s64 ? 64 : 32;
    tl    = s64 ? T64 : T32;
    lanes = xl / 8;
    nb    = 1 << sz;
    a     = (xl == 32) ? (addr & 64'hFFFF_FFFF) : addr;
    w     = (xl == 32) ? (wd & 64'hFFFF_FFFF) : wd;
    off   = int'(a % lanes);
    code  = (xl == 32 && sz == 2'b11) ? 2'b11 : ((a % nb) != 0) ? 2'b01 : 2'b00;
    pre_err = (code != 2'b00);
    ea    = a - 64'(off);
    es    = we ? (((64'd1 << nb) - 64'd1) << off) : 64'd0;
    ew    = 64'd0;
    for (int i = 0; i < lanes; i++) ew[8*i +: 8] = w[8*(i % nb) +: 8];
    r  = 1 + rdly;
    v  = r + 1 + vdly;
    er = 64'd0;
    if (pre_err) rc = 1;
    else if (r > tl) begin rc = tl + 1; code = 2'b10; end
    else if (we) rc = r + 1;
    else begin
      m = (tl > r + 1) ? tl : r + 1;
      if (v <= m) begin rc = v + 1; er = ld_ext(xl, sz, uns, a, rd); end
      else begin rc = m + 1; code = 2'b10; end
    end

    @(negedge clk);
    chk({tag, ".idle_ready"}, 64'(o_req_ready), 64'd1);
    chk({tag, ".idle_rsp"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, ".hold_rdata"}, o_rsp_rdata, hold_rd[sel64]);
    chk({tag, ".hold_code"}, 64'(o_rsp_errcode), 64'(hold_code[sel64]));
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    sel64 = s64; req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; mem_rdata = rd;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      mv = !pre_err && (c <= ((r < tl) ? r : tl));
      chk($sformatf("%s.c%0d.mem_valid", tag, c), 64'(o_mem_valid), 64'(mv));
      chk($sformatf("%s.c%0d.req_ready", tag, c), 64'(o_req_ready), 64'd0);
      chk($sformatf("%s.c%0d.rsp_valid", tag, c), 64'(o_rsp_valid), 64'(c == rc));
      if (mv) begin
        chk({tag, ".mem_addr"}, o_mem_addr, ea);
        chk({tag, ".mem_we"}, 64'(o_mem_we), 64'(we));
        chk({tag, ".mem_wstrb"}, 64'(o_mem_wstrb), es);
        if (we) chk({tag, ".mem_wdata"}, o_mem_wdata, ew);
        l_addr = o_mem_addr; l_wstrb = 64'(o_mem_wstrb); l_wdata = o_mem_wdata;
      end
      if (c == rc) begin
        chk({tag, ".rsp_rdata"}, o_rsp_rdata, er);
        chk({tag, ".rsp_err"}, 64'(o_rsp_err), 64'(code != 2'b00));
        chk({tag, ".rsp_errcode"}, 64'(o_rsp_errcode), 64'(code));
        l_rdata = o_rsp_rdata; l_code = o_rsp_errcode; l_rc = c;
      end
      mem_ready  = (c == r);
      mem_rvalid = (c == v) || (c <= r && $urandom_range(0, 1) == 1);
    end
    hold_rd[s64]   = er;
    hold_code[s64] = code;
  endtask

  initial begin
    reset = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    hold_rd[0] = '0; hold_rd[1] = '0; hold_code[0] = '0; hold_code[1] = '0;
    l_addr = '0; l_wstrb = '0; l_wdata = '0; l_rdata = '0; l_code = '0; l_rc = 0;

    repeat (2) @(negedge clk);
    chk("rst.mem_valid", 64'(o_mem_valid), 64'd0);
    chk("rst.mem_we", 64'(o_mem_we), 64'd0);
    chk("rst.mem_addr", o_mem_addr, 64'd0);
    chk("rst.mem_wstrb", 64'(o_mem_wstrb), 64'd0);
    chk("rst.mem_wdata", o_mem_wdata, 64'd0);
    chk("rst.rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst.rsp_rdata", o_rsp_rdata, 64'd0);
    chk("rst.rsp_err", 64'(o_rsp_err), 64'd0);
    chk("rst.rsp_errcode", 64'(o_rsp_errcode), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", 64'(o_req_ready), 64'd1);

    // Store byte, grant in cycle 1.
    txn(1'b0, 1'b1, 2'b00, 1'b0, 64'h1003, 64'h0000_00AB, 64'd0, 0, 0, "st_b");
    chk("st_b.addr_const", l_addr, 64'h1000);
    chk("st_b.wstrb_const", l_wstrb, 64'h8);
    chk("st_b.wdata_const", l_wdata, 64'hABAB_ABAB);
    chk("st_b.rsp_cycle", 64'(l_rc), 64'd2);

    // Half loads, rvalid in cycle 4 (the timeout cycle for TIMEOUT=4).
    txn(1'b0, 1'b0, 2'b01, 1'b0, 64'h2002, 64'd0, 64'h8123_4567, 0, 2, "ld_hs");
    chk("ld_hs.rdata_const", l_rdata, 64'hFFFF_8123);
    chk("ld_hs.rsp_cycle", 64'(l_rc), 64'd5);
    txn(1'b0, 1'b0, 2'b01, 1'b1, 64'h2002, 64'd0, 64'h8123_4567, 0, 2, "ld_hu");
    chk("ld_hu.rdata_const", l_rdata, 64'h0000_8123);

    // Misaligned word and illegal size on XLEN=32.
    txn(1'b0, 1'b0, 2'b10, 1'b0, 64'h3001, 64'd0, 64'd0, 0, 0, "mis");
    chk("mis.code_const", 64'(l_code), 64'h1);
    chk("mis.rsp_cycle", 64'(l_rc), 64'd1);
    txn(1'b0, 1'b0, 2'b11, 1'b0, 64'h3000, 64'd0, 64'd0, 0, 0, "ill");
    chk("ill.code_const", 64'(l_code), 64'h3);

    // Timeout with mem_ready held low, then a late mem_rvalid in IDLE.
    txn(1'b0, 1'b0, 2'b10, 1'b0, 64'h4000, 64'd0, 64'd0, 99, 0, "tmo");
    chk("tmo.code_const", 64'(l_code), 64'h2);
    chk("tmo.rsp_cycle", 64'(l_rc), 64'd5);
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rv.rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("late_rv.mem_valid", 64'(o_mem_valid), 64'd0);
    chk("late_rv.req_ready", 64'(o_req_ready), 64'd1);

    // XLEN=64 dword and unsigned word loads.
    txn(1'b1, 1'b0, 2'b11, 1'b0, 64'h8, 64'd0, 64'hDEAD_BEEF_0123_4567, 1, 1, "ld_d");
    chk("ld_d.rdata_const", l_rdata, 64'hDEAD_BEEF_0123_4567);
    txn(1'b1, 1'b0, 2'b10, 1'b1, 64'hC, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 0, "ld_wu");
    chk("ld_wu.rdata_const", l_rdata, 64'h0000_0000_DEAD_BEEF);

    // Reset while in WAIT_R on the 64-bit unit.
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    sel64 = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 64'h40; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw.req_mv", 64'(o_mem_valid), 64'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rstw.wait_mv", 64'(o_mem_valid), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("rstw.mem_addr", o_mem_addr, 64'd0);
    chk("rstw.mem_we", 64'(o_mem_we), 64'd0);
    chk("rstw.rsp_rdata", o_rsp_rdata, 64'd0);
    chk("rstw.rsp_errcode", 64'(o_rsp_errcode), 64'd0);
    chk("rstw.rsp_valid", 64'(o_rsp_valid), 64'd0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    reset = 1'b1;
    hold_rd[0] = '0; hold_rd[1] = '0; hold_code[0] = '0; hold_code[1] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstw.no_rsp", 64'(o_rsp_valid), 64'd0);
      chk("rstw.ready", 64'(o_req_ready), 64'd1);
    end
    txn(1'b1, 1'b0, 2'b00, 1'b0, 64'h41, 64'd0, 64'h0000_0000_0000_8000, 0, 0, "post_rst");
    chk("post_rst.rdata_const", l_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Randomized traffic on both widths.
    for (int k = 0; k < 40; k++) begin
      logic        s, we, uns;
      logic [1:0]  sz;
      logic [63:0] a;
      s   = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      txn(s, we, sz, uns, a, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 5), $urandom_range(0, 4), $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
